// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers {instr, pcs}, stops fetch on full or pending HLT,
// flushes on taken branch. Optional perf counters are built when FDQ_PERF_COUNTERS_EN is defined.
module fetch_decode_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter logic [3:0]  HLT_OPC = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                f_instr,
  input  logic [15:0]                f_pcs,
  input  logic                       f_valid,
  output logic                       f_stop,
  input  logic                       d_ready,
  output logic                       d_valid,
  output logic [15:0]                d_instr,
  output logic [15:0]                d_pcs,
  input  logic                       flush,
  output logic                       halt_out,
`ifdef FDQ_PERF_COUNTERS_EN
  output logic [15:0]                stall_cycles,
  output logic [15:0]                flush_count,
  output logic [15:0]                bubble_cycles,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halt_pending_q, halt_pending_d;
  logic            halt_out_q, halt_out_d;

  logic        empty, full, enq, deq, in_hlt, head_hlt;
  logic [31:0] head;

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  // Registered state only, so fetch never sees a path from d_ready or flush.
  assign f_stop   = full | halt_pending_q | halt_out_q;
  assign enq      = f_valid & ~f_stop & ~flush;
  assign deq      = d_valid & d_ready & ~flush;
  assign in_hlt   = (f_instr[15:12] == HLT_OPC);
  assign head_hlt = (head[31:28] == HLT_OPC);

  assign d_valid  = ~empty;
  assign d_instr  = d_valid ? head[31:16] : 16'h0000;
  assign d_pcs    = d_valid ? head[15:0] : 16'h0000;
  assign halt_out = halt_out_q;
  assign count    = count_q;

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    halt_pending_d = halt_pending_q;
    halt_out_d     = halt_out_q;
    if (flush) begin
      rd_ptr_d       = wr_ptr_q;
      count_d        = '0;
      halt_pending_d = 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (in_hlt) halt_pending_d = 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        // At most one HLT can be queued, since it blocks later enqueues.
        if (head_hlt) begin
          halt_out_d     = 1'b1;
          halt_pending_d = 1'b0;
        end
      end
      if (enq && !deq)      count_d = count_q + CntW'(1);
      else if (deq && !enq) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      halt_pending_q <= 1'b0;
      halt_out_q     <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      halt_pending_q <= halt_pending_d;
      halt_out_q     <= halt_out_d;
    end
  end

  // Entries are not reset; count==0 guarantees stale data is never presented.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {f_instr, f_pcs};
  end

`ifdef FDQ_PERF_COUNTERS_EN
  logic [15:0] stall_q, stall_d, flushc_q, flushc_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    flushc_d = flushc_q;
    bubble_d = bubble_q;
    if (f_valid && f_stop && stall_q != 16'hFFFF)         stall_d  = stall_q + 16'd1;
    if (flush && !empty && flushc_q != 16'hFFFF)          flushc_d = flushc_q + 16'd1;
    if (!d_valid && !halt_out_q && bubble_q != 16'hFFFF)  bubble_d = bubble_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      flushc_q <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flushc_q <= flushc_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flushc_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=2): stream, backpressure, flush, halt, reset.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] f_instr, f_pcs;
  logic        f_valid, f_stop, d_ready, d_valid, flush, halt_out;
  logic [15:0] d_instr, d_pcs;
  logic [1:0]  count;
`ifdef FDQ_PERF_COUNTERS_EN
  logic [15:0] stall_cycles, flush_count, bubble_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_decode_queue #(.DEPTH(2), .HLT_OPC(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_instr  (f_instr),
    .f_pcs    (f_pcs),
    .f_valid  (f_valid),
    .f_stop   (f_stop),
    .d_ready  (d_ready),
    .d_valid  (d_valid),
    .d_instr  (d_instr),
    .d_pcs    (d_pcs),
    .flush    (flush),
    .halt_out (halt_out),
`ifdef FDQ_PERF_COUNTERS_EN
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .bubble_cycles (bubble_cycles),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    f_valid = v;
    f_instr = ins;
    f_pcs   = pc;
    d_ready = rdy;
    flush   = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #3;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_instr", d_instr, 0);
    chk("rst_d_pcs", d_pcs, 0);
    chk("rst_f_stop", f_stop, 0);
    chk("rst_count", count, 0);
    chk("rst_halt_out", halt_out, 0);
`ifdef FDQ_PERF_COUNTERS_EN
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flushc", flush_count, 0);
    chk("rst_bubble", bubble_cycles, 0);
`endif
    #4 rst = 1'b1;

    // Stream with decode always ready
    drive(1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0);
    tick();
    chk("s1_instr", d_instr, 16'h1234);
    chk("s1_pcs", d_pcs, 16'h0001);
    chk("s1_count", count, 1);
    chk("s1_stop", f_stop, 0);
    drive(1'b1, 16'h2345, 16'h0002, 1'b1, 1'b0);
    tick();
    chk("s2_instr", d_instr, 16'h2345);
    chk("s2_count", count, 1);
    chk("s2_stop", f_stop, 0);
    drive(1'b1, 16'h3456, 16'h0003, 1'b1, 1'b0);
    tick();
    chk("s3_instr", d_instr, 16'h3456);
    chk("s3_pcs", d_pcs, 16'h0003);
    chk("s3_count", count, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("s4_valid", d_valid, 0);
    chk("s4_instr", d_instr, 0);
    chk("s4_count", count, 0);

    // Backpressure
    drive(1'b1, 16'hA001, 16'h0011, 1'b0, 1'b0);
    tick();
    chk("bp1_count", count, 1);
    chk("bp1_stop", f_stop, 0);
    drive(1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0);
    tick();
    chk("bp2_count", count, 2);
    chk("bp2_stop", f_stop, 1);
    drive(1'b1, 16'hA003, 16'h0013, 1'b0, 1'b0);
    tick();
    chk("bp3_count", count, 2);
    chk("bp3_head", d_instr, 16'hA001);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("bp4_head", d_instr, 16'hA002);
    chk("bp4_pcs", d_pcs, 16'h0012);
    chk("bp4_count", count, 1);
    chk("bp4_stop", f_stop, 0);
    tick();
    chk("bp5_count", count, 0);
    chk("bp5_valid", d_valid, 0);

    // Flush drops queue contents and the flush-cycle instruction
    drive(1'b1, 16'hB001, 16'h0021, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hB002, 16'h0022, 1'b0, 1'b0);
    tick();
    chk("fl0_count", count, 2);
    drive(1'b1, 16'hB003, 16'h0023, 1'b1, 1'b1);
    tick();
    chk("fl1_count", count, 0);
    chk("fl1_valid", d_valid, 0);
    chk("fl1_instr", d_instr, 0);
    chk("fl1_stop", f_stop, 0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("fl2_count", count, 0);
    chk("fl2_valid", d_valid, 0);

    // Halt
    drive(1'b1, 16'h1111, 16'h0031, 1'b0, 1'b0);
    tick();
    chk("h1_stop", f_stop, 0);
    drive(1'b1, 16'hF000, 16'h0032, 1'b0, 1'b0);
    tick();
    chk("h2_stop", f_stop, 1);
    chk("h2_count", count, 2);
    drive(1'b1, 16'h3333, 16'h0033, 1'b1, 1'b0);
    tick();
    chk("h3_count", count, 1);
    chk("h3_stop_pending", f_stop, 1);
    chk("h3_head", d_instr, 16'hF000);
    chk("h3_halt", halt_out, 0);
    tick();
    chk("h4_halt", halt_out, 1);
    chk("h4_stop", f_stop, 1);
    chk("h4_count", count, 0);
    tick();
    chk("h5_halt_sticky", halt_out, 1);
    chk("h5_stop", f_stop, 1);
    chk("h5_count", count, 0);

    // Async reset clears the sticky halt between edges
    #1 rst = 1'b0;
    #1;
    chk("r1_halt", halt_out, 0);
    chk("r1_stop", f_stop, 0);
    #1 rst = 1'b1;

    // Speculative halt flushed before dequeue
    drive(1'b1, 16'hF000, 16'h0041, 1'b0, 1'b0);
    tick();
    chk("sp1_stop", f_stop, 1);
    chk("sp1_count", count, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    chk("sp2_count", count, 0);
    chk("sp2_stop", f_stop, 0);
    chk("sp2_halt", halt_out, 0);
    drive(1'b1, 16'h2222, 16'h0042, 1'b0, 1'b0);
    tick();
    chk("sp3_count", count, 1);
    chk("sp3_head", d_instr, 16'h2222);
    chk("sp3_halt", halt_out, 0);

    // Flush coinciding with HLT dequeue: flush wins
    drive(1'b1, 16'hF000, 16'h0043, 1'b0, 1'b0);
    tick();
    chk("fh1_count", count, 2);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("fh2_head", d_instr, 16'hF000);
    chk("fh2_count", count, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    chk("fh3_halt", halt_out, 0);
    chk("fh3_count", count, 0);
    chk("fh3_stop", f_stop, 0);

    // Async reset mid-stream with a full queue
    drive(1'b1, 16'h4444, 16'h0051, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h5555, 16'h0052, 1'b0, 1'b0);
    tick();
    chk("ar0_count", count, 2);
    #2 rst = 1'b0;
    #1;
    chk("ar1_valid", d_valid, 0);
    chk("ar1_count", count, 0);
    chk("ar1_stop", f_stop, 0);
    chk("ar1_instr", d_instr, 0);
`ifdef FDQ_PERF_COUNTERS_EN
    chk("ar1_stall", stall_cycles, 0);
    chk("ar1_flushc", flush_count, 0);
    chk("ar1_bubble", bubble_cycles, 0);
`endif
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    tick();
    chk("ar2_valid", d_valid, 0);
    chk("ar2_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
